pc_gen_pipe: RTL and testbench

Parametrised program-counter generator for the pipelined CPU, replacing the plain load-enable PC register at the head of the IF stage. It selects between sequential increment, branch/jump redirect and exception vector, and honours stalls. A redirect that arrives during a stall is held in a one-entry buffer and applied when the stall releases. It flags misaligned targets and withholds fetch-valid for one boot cycle after reset.

---
 rtl/pc_pkg.sv | 20 ++
 rtl/pc_redirect_buf.sv | 43 ++++
 rtl/pc_gen_pipe.sv | 94 +++++++++
 tb/tb_pc_gen_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the IF-stage program-counter generator.
package pc_pkg;

    typedef enum logic {
        BOOT,
        RUN
    } pc_state_t;

    typedef enum logic [1:0] {
        NONE,
        REDIR,
        EXC
    } buf_kind_t;

    // Mask of the low address bits that must be zero for an aligned fetch.
    function automatic logic [63:0] align_mask(input int align_bits);
        return (64'd1 << align_bits) - 64'd1;
    endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// One-entry holding buffer for a redirect or exception that arrives while the PC is stalled.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             capture,
    input  logic             clear,
    input  logic             excValid,
    input  logic [WIDTH-1:0] excVector,
    input  logic             redirValid,
    input  logic [WIDTH-1:0] redirTarget,
    output logic             pending,
    output logic             bufIsExc,
    output logic [WIDTH-1:0] bufTarget
);

    buf_kind_t kind;

    // An exception entry is sticky: only another exception may replace it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            kind      <= NONE;
            bufTarget <= '0;
        end else if (clear) begin
            kind <= NONE;
        end else if (capture) begin
            if (excValid) begin
                kind      <= EXC;
                bufTarget <= excVector;
            end else if (redirValid && kind != EXC) begin
                kind      <= REDIR;
                bufTarget <= redirTarget;
            end
        end
    end

    assign pending  = (kind != NONE);
    assign bufIsExc = (kind == EXC);

endmodule

// File: rtl/pc_gen_pipe.sv
// Program-counter generator at the head of IF: sequential step, redirect and
// exception vectoring, stall handling with a one-entry redirect buffer.
//
// state | meaning
// BOOT  | one cycle after reset; pc = RESET_VEC, pcValid = 0, inputs ignored
// RUN   | normal fetch; pc advances or loads a target whenever pcWrite = 1
module pc_gen_pipe
    import pc_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter logic [WIDTH-1:0] RESET_VEC  = '0,
    parameter int               STEP       = 4,
    parameter int               ALIGN_BITS = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcWrite,
    input  logic             redirValid,
    input  logic [WIDTH-1:0] redirTarget,
    input  logic             excValid,
    input  logic [WIDTH-1:0] excVector,
    output logic [WIDTH-1:0] pc,
    output logic             pcValid,
    output logic             misalign,
    output logic             pending
);

    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(align_mask(ALIGN_BITS));
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);

    pc_state_t        state;
    logic             bufIsExc;
    logic [WIDTH-1:0] bufTarget;
    logic             load;
    logic [WIDTH-1:0] target;
    logic             runAdvance;
    logic             runStall;

    assign runAdvance = (state == RUN) && pcWrite;
    assign runStall   = (state == RUN) && !pcWrite;

    pc_redirect_buf #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk        (clk),
        .reset      (reset),
        .capture    (runStall),
        .clear      (runAdvance),
        .excValid   (excValid),
        .excVector  (excVector),
        .redirValid (redirValid),
        .redirTarget(redirTarget),
        .pending    (pending),
        .bufIsExc   (bufIsExc),
        .bufTarget  (bufTarget)
    );

    // A fresh redirect does not pre-empt a buffered exception.
    always_comb begin
        load   = 1'b0;
        target = pc;
        if (excValid) begin
            load   = 1'b1;
            target = excVector;
        end else if (redirValid && !bufIsExc) begin
            load   = 1'b1;
            target = redirTarget;
        end else if (pending) begin
            load   = 1'b1;
            target = bufTarget;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            pc       <= RESET_VEC;
            pcValid  <= 1'b0;
            misalign <= 1'b0;
        end else if (state == BOOT) begin
            state   <= RUN;
            pcValid <= 1'b1;
        end else if (pcWrite) begin
            if (load) begin
                pc       <= target & ~LOW_MASK;
                misalign <= |(target & LOW_MASK);
            end else begin
                pc       <= pc + STEP_W;
                misalign <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_pipe.sv
// Bench for pc_gen_pipe: directed scenarios then random traffic, two widths side by side.
module tb_pc_gen_pipe;

    logic        clk;
    logic        reset;
    logic        pcWrite;
    logic        redirValid;
    logic [31:0] redirTarget;
    logic        excValid;
    logic [31:0] excVector;

    logic [31:0] pc;
    logic        pcValid, misalign, pending;
    logic [7:0]  pc8;
    logic        pcValid8, misalign8, pending8;

    int checks   = 0;
    int failures = 0;

    pc_gen_pipe #(.WIDTH(32)) dut32 (
        .clk        (clk),
        .reset      (reset),
        .pcWrite    (pcWrite),
        .redirValid (redirValid),
        .redirTarget(redirTarget),
        .excValid   (excValid),
        .excVector  (excVector),
        .pc         (pc),
        .pcValid    (pcValid),
        .misalign   (misalign),
        .pending    (pending)
    );

    pc_gen_pipe #(.WIDTH(8), .RESET_VEC(8'h00)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .pcWrite    (pcWrite),
        .redirValid (redirValid),
        .redirTarget(redirTarget[7:0]),
        .excValid   (excValid),
        .excVector  (excVector[7:0]),
        .pc         (pc8),
        .pcValid    (pcValid8),
        .misalign   (misalign8),
        .pending    (pending8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model, index 0 = 32-bit instance, 1 = 8-bit instance.
    logic [31:0] wmask [2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
    logic [31:0] m_pc  [2];
    logic [31:0] m_tgt [2];
    bit          m_run [2];
    bit          m_mis [2];
    bit          m_has [2];
    bit          m_exc [2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pc[i]  = 32'h0;
            m_tgt[i] = 32'h0;
            m_run[i] = 0;
            m_mis[i] = 0;
            m_has[i] = 0;
            m_exc[i] = 0;
        end
    endtask

    task automatic model_load(input int i, input logic [31:0] t);
        m_pc[i]  = t & wmask[i] & ~32'h3;
        m_mis[i] = (t[1:0] != 2'b00);
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (!m_run[i]) begin
                m_run[i] = 1;
            end else if (pcWrite) begin
                if (excValid)
                    model_load(i, excVector);
                else if (redirValid && !(m_has[i] && m_exc[i]))
                    model_load(i, redirTarget);
                else if (m_has[i])
                    model_load(i, m_tgt[i]);
                else begin
                    m_pc[i]  = (m_pc[i] + 32'd4) & wmask[i];
                    m_mis[i] = 0;
                end
                m_has[i] = 0;
            end else begin
                if (excValid) begin
                    m_has[i] = 1;
                    m_exc[i] = 1;
                    m_tgt[i] = excVector;
                end else if (redirValid && !(m_has[i] && m_exc[i])) begin
                    m_has[i] = 1;
                    m_exc[i] = 0;
                    m_tgt[i] = redirTarget;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("pc32",      pc,             m_pc[0]);
        chk("valid32",   32'(pcValid),   32'(m_run[0]));
        chk("misalign32",32'(misalign),  32'(m_mis[0]));
        chk("pending32", 32'(pending),   32'(m_has[0]));
        chk("pc8",       32'(pc8),       m_pc[1]);
        chk("valid8",    32'(pcValid8),  32'(m_run[1]));
        chk("misalign8", 32'(misalign8), 32'(m_mis[1]));
        chk("pending8",  32'(pending8),  32'(m_has[1]));
    endtask

    task automatic cycle(input bit pw, input bit rv, input logic [31:0] rt,
                         input bit ev, input logic [31:0] et);
        pcWrite     = pw;
        redirValid  = rv;
        redirTarget = rt;
        excValid    = ev;
        excVector   = et;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        reset       = 1'b0;
        pcWrite     = 1'b1;
        redirValid  = 1'b0;
        redirTarget = 32'h0;
        excValid    = 1'b0;
        excVector   = 32'h0;
        model_reset();

        #2;
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        chk("rst_pc", pc, 32'h0);
        chk("rst_valid", 32'(pcValid), 32'h0);

        reset = 1'b1;
        #1;
        compare_all();
        chk("preboot_valid", 32'(pcValid), 32'h0);

        idle();
        chk("boot_pc", pc, 32'h0);
        chk("boot_valid", 32'(pcValid), 32'h1);
        idle();
        chk("seq_pc4", pc, 32'h4);
        idle();
        chk("seq_pc8", pc, 32'h8);
        idle();
        idle();
        chk("seq_pc10", pc, 32'h10);

        // stalled redirect
        cycle(1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        chk("stall_pending", 32'(pending), 32'h1);
        chk("stall_pc", pc, 32'h10);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("stall_hold_pc", pc, 32'h10);
        idle();
        chk("release_pc", pc, 32'h100);
        chk("release_pending", 32'(pending), 32'h0);
        idle();
        chk("after_release_pc", pc, 32'h104);

        // buffered exception beats later redirects
        cycle(1'b0, 1'b1, 32'h200, 1'b1, 32'h80);
        cycle(1'b0, 1'b1, 32'h300, 1'b0, 32'h0);
        idle();
        chk("prio_pc", pc, 32'h80);

        // buffered exception beats a fresh redirect on the release edge
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h40);
        cycle(1'b1, 1'b1, 32'h600, 1'b0, 32'h0);
        chk("prio_release_pc", pc, 32'h40);

        // fresh redirect beats a buffered redirect on the release edge
        cycle(1'b0, 1'b1, 32'h700, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h800, 1'b0, 32'h0);
        chk("fresh_beats_buf_pc", pc, 32'h800);

        // misaligned target
        cycle(1'b1, 1'b1, 32'h103, 1'b0, 32'h0);
        chk("mis_pc", pc, 32'h100);
        chk("mis_flag", 32'(misalign), 32'h1);
        idle();
        chk("mis_next_pc", pc, 32'h104);
        chk("mis_clear", 32'(misalign), 32'h0);

        // 8-bit wrap
        cycle(1'b1, 1'b1, 32'hFC, 1'b0, 32'h0);
        chk("wrap_pre_pc8", 32'(pc8), 32'hFC);
        idle();
        chk("wrap_pc8", 32'(pc8), 32'h00);
        chk("wrap_mis8", 32'(misalign8), 32'h0);
        chk("nowrap_pc32", pc, 32'h100);

        // reset between edges while a redirect is buffered
        cycle(1'b0, 1'b1, 32'h500, 1'b0, 32'h0);
        chk("pre_rst_pending", 32'(pending), 32'h1);
        #3 reset = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("async_rst_pending", 32'(pending), 32'h0);
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_valid", 32'(pcValid), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        reset = 1'b1;
        idle();
        idle();
        chk("post_rst_pc", pc, 32'h4);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] rt, et;
            rt = $urandom;
            et = $urandom;
            if ($urandom_range(0, 1) == 0) rt[1:0] = 2'b00;
            if ($urandom_range(0, 1) == 0) et[1:0] = 2'b00;
            if ($urandom_range(0, 149) == 0) begin
                #2 reset = 1'b0;
                #1;
                model_reset();
                compare_all();
                @(posedge clk);
                #1 reset = 1'b1;
            end
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, rt,
                  $urandom_range(0, 7) == 0, et);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
